// File: rtl/microcode_pkg.sv
// Shared types and microword/dispatch field layout for the microcode sequencer.
package microcode_pkg;

  typedef enum logic [1:0] {
    SEQ_NEXT   = 2'b00,
    SEQ_JUMP   = 2'b01,
    SEQ_BRANCH = 2'b10,
    SEQ_END    = 2'b11
  } seq_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  localparam int SEQ_W          = 2;
  localparam int DISP_VALID_BIT = 0;
  localparam int DISP_ADDR_LSB  = 1;

  // Microword = {seq, next_addr, ctrl}, ctrl in the low bits.
  function automatic int mw_width(input int cw, input int aw);
    return cw + aw + SEQ_W;
  endfunction

  function automatic int na_lsb(input int cw);
    return cw;
  endfunction

  function automatic int seq_lsb(input int cw, input int aw);
    return cw + aw;
  endfunction

endpackage

// File: rtl/microcode_store.sv
// Writable control store: one synchronous write port, asynchronous read.
module microcode_store #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode control unit: opcode dispatch, per-word next-address sequencing,
// halt/resume, and fault reporting (undefined opcode, overrun, watchdog).
module microcode_sequencer
  import microcode_pkg::*;
#(
  parameter int          CTRL_WIDTH  = 32,
  parameter int          DEPTH       = 256,
  parameter int          OP_WIDTH    = 6,
  parameter int unsigned HALT_OPCODE = 'h3F,
  parameter int          MAX_STEPS   = 64,
  localparam int         AW          = $clog2(DEPTH),
  localparam int         MW          = CTRL_WIDTH + AW + SEQ_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid_i,
  output logic                  op_ready_o,
  input  logic [OP_WIDTH-1:0]   opcode_i,
  input  logic                  cond_i,
  output logic [CTRL_WIDTH-1:0] ctrl_o,
  output logic                  ctrl_valid_o,
  output logic                  eos_o,
  output logic                  halted_o,
  output logic                  fault_o,
  input  logic                  resume_i,
  input  logic                  prog_we_i,
  input  logic                  prog_sel_i,
  input  logic [AW-1:0]         prog_addr_i,
  input  logic [MW-1:0]         prog_data_i
);

  localparam int NOPS    = 2 ** OP_WIDTH;
  localparam int SW      = $clog2(MAX_STEPS + 1);
  localparam int NA_LSB  = na_lsb(CTRL_WIDTH);
  localparam int SEQ_LSB = seq_lsb(CTRL_WIDTH, AW);
  localparam logic [OP_WIDTH-1:0] HALT_OP = OP_WIDTH'(HALT_OPCODE);

  state_e          state_q;
  logic [AW-1:0]   upc_q, upc_d;
  logic [MW-1:0]   word_q;
  logic            vld_q, fault_q, halted_q;
  logic [SW-1:0]   step_q;
  logic [NOPS-1:0] disp_vld_q;
  logic [AW-1:0]   disp_start_q [NOPS];

  seq_e          cur_seq;
  logic          eos, accept, prog_ok, seq_fault, wd_fault;
  logic [AW-1:0] rd_addr;
  logic [MW-1:0] rd_data;

  assign cur_seq    = seq_e'(word_q[SEQ_LSB +: SEQ_W]);
  assign eos        = vld_q && (cur_seq == SEQ_END);
  assign op_ready_o = (state_q == ST_IDLE) || ((state_q == ST_RUN) && eos);
  assign accept     = op_valid_i && op_ready_o;
  assign prog_ok    = prog_we_i && (state_q != ST_RUN);
  assign wd_fault   = (step_q == SW'(MAX_STEPS));

  // Sequential fall-through off the top of the store is a fault, never a wrap.
  always_comb begin
    upc_d     = upc_q + 1'b1;
    seq_fault = 1'b0;
    case (cur_seq)
      SEQ_JUMP:   upc_d = word_q[NA_LSB +: AW];
      SEQ_BRANCH: if (cond_i) upc_d = word_q[NA_LSB +: AW];
                  else        seq_fault = (upc_q == AW'(DEPTH - 1));
      SEQ_NEXT:   seq_fault = (upc_q == AW'(DEPTH - 1));
      default:    ;
    endcase
  end

  // One read port serves both dispatch start and in-segment fetch.
  assign rd_addr = accept ? disp_start_q[opcode_i] : upc_d;

  microcode_store #(.WIDTH(MW), .DEPTH(DEPTH)) u_store (
    .clk    (clk),
    .we_i   (prog_ok && !prog_sel_i),
    .waddr_i(prog_addr_i),
    .wdata_i(prog_data_i),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      upc_q    <= '0;
      word_q   <= '0;
      vld_q    <= 1'b0;
      step_q   <= '0;
      fault_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      if (accept) begin
        if (opcode_i == HALT_OP) begin
          state_q  <= ST_HALTED;
          halted_q <= 1'b1;
          vld_q    <= 1'b0;
          word_q   <= '0;
        end else if (!disp_vld_q[opcode_i]) begin
          state_q <= ST_IDLE;
          fault_q <= 1'b1;
          vld_q   <= 1'b0;
          word_q  <= '0;
        end else begin
          state_q <= ST_RUN;
          upc_q   <= rd_addr;
          word_q  <= rd_data;
          vld_q   <= 1'b1;
          step_q  <= SW'(1);
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (cur_seq == SEQ_END) begin
              state_q <= ST_IDLE;
              vld_q   <= 1'b0;
              word_q  <= '0;
            end else if (seq_fault || wd_fault) begin
              state_q <= ST_IDLE;
              fault_q <= 1'b1;
              vld_q   <= 1'b0;
              word_q  <= '0;
            end else begin
              upc_q  <= upc_d;
              word_q <= rd_data;
              step_q <= step_q + 1'b1;
            end
          end
          ST_HALTED: begin
            if (resume_i) begin
              state_q  <= ST_IDLE;
              halted_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Dispatch reads see the pre-edge entry, so a same-cycle write never races an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) disp_vld_q <= '0;
    else if (prog_ok && prog_sel_i)
      disp_vld_q[prog_addr_i[OP_WIDTH-1:0]] <= prog_data_i[DISP_VALID_BIT];
  end

  always_ff @(posedge clk) begin
    if (prog_ok && prog_sel_i)
      disp_start_q[prog_addr_i[OP_WIDTH-1:0]] <= prog_data_i[DISP_ADDR_LSB +: AW];
  end

  assign ctrl_o       = word_q[CTRL_WIDTH-1:0];
  assign ctrl_valid_o = vld_q;
  assign eos_o        = eos;
  assign halted_o     = halted_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed vector table, corner sequences,
// then random traffic against a behavioural model of the sequencer.
module tb_microcode_sequencer;
  localparam int CW = 32, DEPTH = 256, AW = 8, OPW = 6, MW = CW + AW + 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           op_valid = 0, cond = 0, resume = 0, prog_we = 0, prog_sel = 0;
  logic [OPW-1:0] opcode = '0;
  logic [AW-1:0]  prog_addr = '0;
  logic [MW-1:0]  prog_data = '0;
  logic           op_ready, ctrl_valid, eos, halted, fault;
  logic [CW-1:0]  ctrl;

  microcode_sequencer dut (
    .clk(clk), .rst_n(rst_n), .op_valid_i(op_valid), .op_ready_o(op_ready),
    .opcode_i(opcode), .cond_i(cond), .ctrl_o(ctrl), .ctrl_valid_o(ctrl_valid),
    .eos_o(eos), .halted_o(halted), .fault_o(fault), .resume_i(resume),
    .prog_we_i(prog_we), .prog_sel_i(prog_sel), .prog_addr_i(prog_addr),
    .prog_data_i(prog_data)
  );

  int n_cmp = 0, n_bad = 0;

  // Output bundle: {fault, halted, ready, eos, valid, ctrl}
  function automatic logic [36:0] dut_out();
    return {fault, halted, op_ready, eos, ctrl_valid, ctrl};
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got flt/hlt/rdy/eos/vld=%b ctrl=%h, want %b ctrl=%h",
               name, act[36:32], act[31:0], exp[36:32], exp[31:0]);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [MW-1:0] m_mem [DEPTH];
  bit            m_dv  [64];
  int            m_ds  [64];
  int            m_mode;            // 0 idle, 1 running, 2 halted
  int            m_pc, m_steps;
  logic [MW-1:0] m_word;
  bit            m_fault;

  function automatic logic [36:0] m_expect();
    bit v, e, r;
    logic [31:0] c;
    v = (m_mode == 1);
    c = v ? m_word[31:0] : 32'h0;
    e = v && (m_word[41:40] == 2'd3);
    r = (m_mode == 0) || e;
    return {m_fault, (m_mode == 2), r, e, v, c};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_steps = 0; m_word = '0; m_fault = 0;
    for (int i = 0; i < 64; i++) m_dv[i] = 0;
  endtask

  task automatic model_edge();
    logic [36:0] e;
    int prev, s;
    bit acc;
    if (!rst_n) return;
    e = m_expect();
    prev = m_mode;
    m_fault = 0;
    acc = op_valid && e[34];
    if (acc) begin
      if (opcode == 6'h3F) m_mode = 2;
      else if (!m_dv[opcode]) begin m_fault = 1; m_mode = 0; end
      else begin m_pc = m_ds[opcode]; m_word = m_mem[m_pc]; m_steps = 1; m_mode = 1; end
    end else if (m_mode == 1) begin
      s = int'(m_word[41:40]);
      if (s == 3) m_mode = 0;
      else if (m_steps >= 64) begin m_fault = 1; m_mode = 0; end
      else begin
        if (s == 1 || (s == 2 && cond)) m_pc = int'(m_word[39:32]);
        else if (m_pc == DEPTH - 1) begin m_fault = 1; m_mode = 0; end
        else m_pc = m_pc + 1;
        if (m_mode == 1) begin m_word = m_mem[m_pc]; m_steps = m_steps + 1; end
      end
    end else if (m_mode == 2 && resume) m_mode = 0;
    if (prog_we && prev != 1) begin
      if (prog_sel) begin
        m_dv[prog_addr[5:0]] = prog_data[0];
        m_ds[prog_addr[5:0]] = int'(prog_data[8:1]);
      end else m_mem[prog_addr] = prog_data;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] mw(input logic [1:0] sq, input logic [7:0] na, input logic [31:0] c);
    return {sq, na, c};
  endfunction

  function automatic logic [MW-1:0] dent(input logic [7:0] start);
    return MW'({start, 1'b1});
  endfunction

  task automatic prog(input bit sel, input logic [7:0] addr, input logic [MW-1:0] data);
    prog_we = 1; prog_sel = sel; prog_addr = addr; prog_data = data;
    tick();
    prog_we = 0;
  endtask

  typedef struct {
    bit v; logic [5:0] op; bit c; bit r;
    logic [31:0] ctrl; bit vld, eos, rdy, hlt, flt;
  } vec_t;

  function automatic vec_t mk(input bit v, input logic [5:0] op, input bit c, input bit r,
                              input logic [31:0] ct, input bit vl, input bit es,
                              input bit rd, input bit hl, input bit fl);
    vec_t t;
    t.v = v; t.op = op; t.c = c; t.r = r; t.ctrl = ct;
    t.vld = vl; t.eos = es; t.rdy = rd; t.hlt = hl; t.flt = fl;
    return t;
  endfunction

  localparam logic [36:0] IDLE_OUT = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
  localparam logic [36:0] FLT_OUT  = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

  function automatic logic [36:0] runw(input logic [31:0] c, input bit e);
    return {1'b0, 1'b0, e, e, 1'b1, c};
  endfunction

  vec_t tbl[$];

  initial begin
    int r;
    logic [1:0] sq;
    model_reset();
    #12;
    check("reset", dut_out(), IDLE_OUT);
    rst_n = 1;
    @(posedge clk); #1;

    prog(0, 8'h10, mw(2'd3, 8'h00, 32'h318));
    prog(1, 8'h23, dent(8'h10));
    prog(0, 8'h20, mw(2'd0, 8'h00, 32'hA020));
    prog(0, 8'h21, mw(2'd2, 8'h30, 32'hA021));
    prog(0, 8'h22, mw(2'd3, 8'h00, 32'hA022));
    prog(0, 8'h30, mw(2'd3, 8'h00, 32'hA030));
    prog(1, 8'h2B, dent(8'h20));
    prog(0, 8'h40, mw(2'd1, 8'h40, 32'hBEEF));
    prog(1, 8'h11, dent(8'h40));

    tbl.push_back(mk(1, 6'h23, 0, 0, 32'h318,  1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'h0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6'h2B, 1, 0, 32'hA020, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0, 32'hA021, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 1, 0, 32'hA030, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'h0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6'h2B, 0, 0, 32'hA020, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'hA021, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'hA022, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'h0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6'h23, 0, 0, 32'h318,  1, 1, 1, 0, 0));
    tbl.push_back(mk(1, 6'h2B, 0, 0, 32'hA020, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'hA021, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'hA022, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'h0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6'h05, 0, 0, 32'h0,    0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'h0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6'h3F, 0, 0, 32'h0,    0, 0, 0, 1, 0));
    tbl.push_back(mk(1, 6'h23, 0, 0, 32'h0,    0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 6'h00, 0, 1, 32'h0,    0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 6'h23, 0, 0, 32'h318,  1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 6'h00, 0, 0, 32'h0,    0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      op_valid = tbl[i].v; opcode = tbl[i].op; cond = tbl[i].c; resume = tbl[i].r;
      tick();
      check($sformatf("vec%0d", i), dut_out(),
            {tbl[i].flt, tbl[i].hlt, tbl[i].rdy, tbl[i].eos, tbl[i].vld, tbl[i].ctrl});
    end
    op_valid = 0; resume = 0; cond = 0;

    // Same-cycle dispatch write and accept: old entry wins, new one applies afterwards.
    op_valid = 1; opcode = 6'h2B;
    prog_we = 1; prog_sel = 1; prog_addr = 8'h2B; prog_data = dent(8'h10);
    tick();
    op_valid = 0; prog_we = 0;
    check("disp_old", dut_out(), runw(32'hA020, 0));
    tick(); tick(); tick();
    check("disp_old_end", dut_out(), IDLE_OUT);
    op_valid = 1; tick(); op_valid = 0;
    check("disp_new", dut_out(), runw(32'h318, 1));
    tick();
    prog(1, 8'h2B, dent(8'h20));

    // Watchdog on a JUMP-to-self loop.
    op_valid = 1; opcode = 6'h11; tick(); op_valid = 0;
    check("wd_w0", dut_out(), runw(32'hBEEF, 0));
    for (int i = 1; i < 64; i++) begin
      tick();
      check($sformatf("wd_w%0d", i), dut_out(), runw(32'hBEEF, 0));
    end
    tick();
    check("wd_fault", dut_out(), FLT_OUT);
    tick();
    check("wd_after", dut_out(), IDLE_OUT);

    // Programming writes during RUN are dropped.
    op_valid = 1; opcode = 6'h2B; tick(); op_valid = 0;
    check("pr_w0", dut_out(), runw(32'hA020, 0));
    prog(0, 8'h21, mw(2'd3, 8'h00, 32'hDEAD));
    check("pr_w1", dut_out(), runw(32'hA021, 0));
    tick();
    check("pr_w2", dut_out(), runw(32'hA022, 1));
    tick();
    op_valid = 1; tick(); op_valid = 0;
    tick();
    check("pr_keep", dut_out(), runw(32'hA021, 0));
    tick(); tick();

    // Asynchronous reset mid-segment.
    op_valid = 1; opcode = 6'h2B; tick(); op_valid = 0;
    check("rst_pre", dut_out(), runw(32'hA020, 0));
    #2 rst_n = 0;
    #1 check("rst_async", dut_out(), IDLE_OUT);
    model_reset();
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    op_valid = 1; opcode = 6'h23; tick(); op_valid = 0;
    check("rst_disp_cleared", dut_out(), FLT_OUT);
    tick();

    // Random program and traffic against the model.
    for (int a = 0; a < DEPTH; a++) begin
      r = $urandom_range(0, 9);
      sq = (r < 4) ? 2'd0 : (r < 6) ? 2'd2 : (r < 7) ? 2'd1 : 2'd3;
      prog(0, 8'(a), mw(sq, 8'($urandom_range(0, 255)), $urandom));
    end
    for (int o = 0; o < 63; o++)
      prog(1, 8'(o), ($urandom_range(0, 3) != 0) ? dent(8'($urandom_range(0, 255))) : '0);
    for (int n = 0; n < 3000; n++) begin
      op_valid = ($urandom_range(0, 2) != 0);
      opcode   = ($urandom_range(0, 19) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      cond     = 1'($urandom_range(0, 1));
      resume   = ($urandom_range(0, 3) == 0);
      prog_we  = ($urandom_range(0, 19) == 0);
      prog_sel = 1'($urandom_range(0, 1));
      prog_addr = 8'($urandom_range(0, 255));
      prog_data = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 32'($urandom)};
      tick();
      check($sformatf("rand%0d", n), dut_out(), m_expect());
    end
    prog_we = 0; op_valid = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
